// File: rtl/bls_pkg.sv
// Shared constants, stage-count helper and stage record for the bls_pipe
// borrow-lookahead subtractor.
package bls_pkg;

  localparam int unsigned BLS_WIDTH = 16;
  localparam int unsigned BLS_BLOCK = 4;

  function automatic int unsigned bls_ngrp(input int unsigned width,
                                           input int unsigned block);
    return width / block;
  endfunction

  // One pipeline slot at the default group size: the carry is the carry out of
  // the group already resolved, the operand slices are the next ones to resolve.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [BLS_BLOCK-1:0] a;
    logic [BLS_BLOCK-1:0] b;
    logic [BLS_BLOCK-1:0] d;
  } bls_stage_t;

endpackage

// File: rtl/bls_group.sv
// Combinational BLOCK-bit borrow-lookahead group computing a + ~b + cin.
module bls_group
  import bls_pkg::*;
#(
  parameter int unsigned BLOCK = BLS_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] d,
  output logic             cout
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;
  logic             sop;
  logic             prop;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Each carry is a flat sum of products over all lower generate/propagate
  // terms rather than a chain through the previous carry.
  always_comb begin
    c    = '0;
    sop  = 1'b0;
    prop = 1'b1;
    c[0] = cin;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      sop  = 1'b0;
      prop = 1'b1;
      for (int unsigned k = 0; k <= i; k++) begin
        sop  = sop | (g[i-k] & prop);
        prop = prop & p[i-k];
      end
      c[i+1] = sop | (prop & cin);
    end
  end

  assign d    = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];

endmodule

// File: rtl/bls_pipe.sv
// Pipelined borrow-lookahead subtractor, one register stage per BLOCK-bit group.
// Define BLS_PIPE_ABS_OUT_EN for an extra stage that outputs |A - B|.
module bls_pipe
  import bls_pkg::*;
#(
  parameter int unsigned WIDTH = BLS_WIDTH,
  parameter int unsigned BLOCK = BLS_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             neg
);

  if (WIDTH < 2 || BLOCK == 0 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $fatal(1, "bls_pipe: WIDTH must be >= 2 and a multiple of BLOCK");
  end

  localparam int unsigned NGRP = bls_ngrp(WIDTH, BLOCK);

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage k keeps only the operand bits of groups above k and the difference
  // bits of groups 0..k, so each register is exactly as wide as it must be.
  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    localparam int unsigned IW = (NGRP - k) * BLOCK;
    localparam int unsigned DW = (k + 1) * BLOCK;

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [BLOCK-1:0] d_grp;
    logic             c_grp;
    logic             v_q;
    logic             c_q;
    logic [DW-1:0]    d_q;

    bls_group #(.BLOCK(BLOCK)) u_group (
      .a    (a_in[BLOCK-1:0]),
      .b    (b_in[BLOCK-1:0]),
      .cin  (c_in),
      .d    (d_grp),
      .cout (c_grp)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b1;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= c_grp;
      end
    end

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b;
      assign c_in = 1'b1;
      assign v_in = in_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          d_q <= '0;
        end else if (adv) begin
          d_q <= d_grp;
        end
      end
    end else begin : g_body
      assign a_in = g_stage[k-1].g_opd.a_q;
      assign b_in = g_stage[k-1].g_opd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          d_q <= '0;
        end else if (adv) begin
          d_q <= {d_grp, g_stage[k-1].d_q};
        end
      end
    end

    if (k < NGRP - 1) begin : g_opd
      logic [IW-BLOCK-1:0] a_q;
      logic [IW-BLOCK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[IW-1:BLOCK];
          b_q <= b_in[IW-1:BLOCK];
        end
      end
    end
  end

  logic             raw_valid;
  logic [WIDTH-1:0] raw_diff;
  logic             raw_neg;

  assign raw_valid = g_stage[NGRP-1].v_q;
  assign raw_diff  = g_stage[NGRP-1].d_q;
  assign raw_neg   = ~g_stage[NGRP-1].c_q;

`ifdef BLS_PIPE_ABS_OUT_EN
  logic             abs_valid;
  logic [WIDTH-1:0] abs_diff;
  logic             abs_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      abs_valid <= 1'b0;
      abs_diff  <= '0;
      abs_neg   <= 1'b0;
    end else if (adv) begin
      abs_valid <= raw_valid;
      abs_diff  <= raw_neg ? ('0 - raw_diff) : raw_diff;
      abs_neg   <= raw_neg;
    end
  end

  assign out_valid = abs_valid;
  assign diff      = abs_diff;
  assign neg       = abs_neg;
`else
  assign out_valid = raw_valid;
  assign diff      = raw_diff;
  assign neg       = raw_neg;
`endif

endmodule

// File: tb/tb_bls_pipe.sv
// Self-checking bench for bls_pipe (WIDTH=16, BLOCK=4) with an in-order
// scoreboard; follows BLS_PIPE_ABS_OUT_EN for latency and magnitude output.
module tb_bls_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned BLOCK = 4;
`ifdef BLS_PIPE_ABS_OUT_EN
  localparam int unsigned LAT = 5;
  localparam bit          ABS = 1'b1;
`else
  localparam int unsigned LAT = 4;
  localparam bit          ABS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff;
  logic        neg;

  bls_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        n;
    int unsigned acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned nchk = 0;
  int unsigned nfail = 0;
  int unsigned cyc = 0;
  int unsigned npop = 0;
  bit          chk_lat = 1'b0;
  bit          stall_prev = 1'b0;
  bit          bp_done = 1'b0;
  logic [15:0] held_d;
  logic        held_n;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input int unsigned acc);
    exp_t        e;
    logic [16:0] full;
    full  = {1'b0, x} - {1'b0, y};
    e.n   = full[16];
    e.d   = full[15:0];
    if (ABS && e.n) e.d = y - x;
    e.acc = acc;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      nchk++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        nfail++;
        $display("FAIL in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
      end
      if (stall_prev) begin
        nchk++;
        if (out_valid !== 1'b1 || diff !== held_d || neg !== held_n) begin
          nfail++;
          $display("FAIL stall_hold: got v=%b d=%h n=%b expected v=1 d=%h n=%b",
                   out_valid, diff, neg, held_d, held_n);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cyc));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_output: got d=%h n=%b expected no output", diff, neg);
        end else begin
          mon_e = exp_q.pop_front();
          npop++;
          nchk++;
          if (diff !== mon_e.d || neg !== mon_e.n) begin
            nfail++;
            $display("FAIL result: got d=%h n=%b expected d=%h n=%b", diff, neg, mon_e.d, mon_e.n);
          end
          if (chk_lat) begin
            nchk++;
            if (cyc - mon_e.acc != LAT) begin
              nfail++;
              $display("FAIL latency: got %0d expected %0d", cyc - mon_e.acc, LAT);
            end
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held_d     = diff;
      held_n     = neg;
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    int unsigned n = 0;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      nchk++;
      nfail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    align();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    nchk++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    nchk++;
    if (diff !== 16'h0000) begin
      nfail++;
      $display("FAIL reset_diff: got %h expected 0000", diff);
    end
    nchk++;
    if (neg !== 1'b0) begin
      nfail++;
      $display("FAIL reset_neg: got %b expected 0", neg);
    end
    align();
    rst = 1'b0;
    @(negedge clk);
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    align();
  endtask

  task automatic test_basic();
    int unsigned p0 = npop;
    chk_lat = 1'b1;
    send(16'h1234, 16'h0234);
    drain(20);
    nchk++;
    if (npop - p0 != 1) begin
      nfail++;
      $display("FAIL basic_count: got %0d expected 1", npop - p0);
    end
    @(negedge clk);
    nchk++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL basic_single_pulse: got %b expected 0", out_valid);
    end
    align();
  endtask

  task automatic test_borrow();
    chk_lat = 1'b1;
    send(16'h1000, 16'h0001);
    send(16'h0000, 16'h0001);
    drain(20);
    align();
  endtask

  task automatic test_equal();
    chk_lat = 1'b1;
    send(16'hFFFF, 16'hFFFF);
    send(16'h0000, 16'h0000);
    send(16'h8000, 16'h7FFF);
    drain(20);
    align();
  endtask

  task automatic test_backpressure();
    int unsigned p0 = npop;
    chk_lat = 1'b0;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) send(16'($urandom), 16'($urandom));
        drain(2000);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          align();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    nchk++;
    if (npop - p0 != 32) begin
      nfail++;
      $display("FAIL bp_count: got %0d expected 32", npop - p0);
    end
    align();
  endtask

  task automatic test_reset_mid();
    int unsigned seen = 0;
    int unsigned p0;
    chk_lat   = 1'b0;
    out_ready = 1'b1;
    send(16'h0011, 16'h0001);
    send(16'h0022, 16'h0002);
    send(16'h0033, 16'h0003);
    rst = 1'b1;
    align();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    nchk++;
    if (seen != 0) begin
      nfail++;
      $display("FAIL reset_mid_flush: got %0d outputs expected 0", seen);
    end
    align();
    p0      = npop;
    chk_lat = 1'b1;
    send(16'h0005, 16'h0003);
    drain(20);
    nchk++;
    if (npop - p0 != 1) begin
      nfail++;
      $display("FAIL reset_mid_after: got %0d outputs expected 1", npop - p0);
    end
    align();
  endtask

  task automatic test_back_to_back();
    int unsigned seen = 0;
    int unsigned bubbles = 0;
    int unsigned stalls = 0;
    int unsigned p0 = npop;
    chk_lat   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a        = 16'($urandom);
      b        = 16'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) stalls++;
      if (out_valid) seen++;
      else if (i >= int'(LAT)) bubbles++;
      align();
    end
    in_valid = 1'b0;
    nchk++;
    if (stalls != 0) begin
      nfail++;
      $display("FAIL stream_stalls: got %0d expected 0", stalls);
    end
    nchk++;
    if (bubbles != 0) begin
      nfail++;
      $display("FAIL stream_bubbles: got %0d expected 0", bubbles);
    end
    nchk++;
    if (seen != 100 - LAT) begin
      nfail++;
      $display("FAIL stream_outputs: got %0d expected %0d", seen, 100 - LAT);
    end
    drain(20);
    nchk++;
    if (npop - p0 != 100) begin
      nfail++;
      $display("FAIL stream_total: got %0d expected 100", npop - p0);
    end
    align();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_equal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
